vec_sweep_checker: RTL
======================

Name: vec_sweep_checker

Overview:
- Synthesizable counterpart of the exhaustive-vector self-checking flow used for gate-level exercises.
- Drives every input combination of an N-input combinational DUT and holds each vector for a fixed number of cycles.
- Compares the DUT output against a reference-model output at the end of each hold window and reports pass/fail, the first failing vector, and its expected/actual values.
- Sits between the stimulus side and the DUT/reference pair on an FPGA judge board; the result is read by a status register block.

Parameters:
- N_IN, 3, DUT input width; the sweep covers 0 .. 2^N_IN-1.
- OUT_W, 1, DUT/reference output width.
- HOLD_CYCLES, 10, cycles each vector is held; must be >= 1.
- STOP_ON_FAIL, 1, 1 = end the sweep at the first mismatch; 0 = sweep all vectors and count errors.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a sweep.
- vec  out  N_IN  stimulus applied to both DUT and reference.
- dut_out  in  OUT_W  DUT response.
- ref_out  in  OUT_W  reference-model response.
- busy  out  1  sweep in progress.
- done  out  1  sweep finished; held until the next accepted start.
- pass  out  1  valid when done: 1 = no mismatch seen.
- fail_vec  out  N_IN  first mismatching vector.
- exp_out  out  OUT_W  ref_out captured at the first mismatch.
- act_out  out  OUT_W  dut_out captured at the first mismatch.
- err_count  out  N_IN+1  number of mismatching vectors, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - vec, busy, done, pass, fail_vec, exp_out, act_out, err_count and the hold counter all go to 0.
  - Reset asserted mid-sweep aborts the sweep immediately. No result is retained.
- States are IDLE, APPLY, FINISH.
- IDLE, or FINISH with start=1 at an edge:
  - Go to APPLY; vec=0, hold_cnt=0, busy=1, done=0, pass=0, err_count=0.
  - fail_vec, exp_out and act_out are cleared to 0.
- APPLY, each edge:
  - If hold_cnt < HOLD_CYCLES-1: hold_cnt++; vec is held.
  - If hold_cnt == HOLD_CYCLES-1, this is the check edge:
    - Compare dut_out != ref_out as a full-width bitwise compare.
    - On mismatch with err_count==0: latch fail_vec=vec, exp_out=ref_out, act_out=dut_out.
    - On any mismatch: err_count++, saturating at 2^(N_IN+1)-1.
    - If a mismatch occurs and STOP_ON_FAIL=1: go to FINISH.
    - Otherwise, if vec == 2^N_IN-1: go to FINISH. This is the terminal vector; vec never wraps.
    - Otherwise: vec++, hold_cnt=0.
- FINISH:
  - busy=0, done=1.
  - pass=1 if and only if no mismatch occurred in the sweep; it is set on the same edge done rises.
  - vec holds its last value.
- start while busy=1 is ignored. start in FINISH restarts a new sweep.
- Latency: with the start-sampling edge as edge 0 and no mismatch, done rises after edge (2^N_IN)*HOLD_CYCLES.
  - Defaults: edge 80.
  - First mismatch at vector k with STOP_ON_FAIL=1: done rises after edge (k+1)*HOLD_CYCLES.
- HOLD_CYCLES=1: every APPLY edge is a check edge; the sweep takes 2^N_IN cycles.
- All outputs are registered. dut_out and ref_out are sampled only on check edges.

Test Plan:
- Correct DUT: dut_out = ref_out = ~(a&b&c), defaults. Pulse start -> done=1, pass=1, err_count=0 at edge 80; busy high edges 0..79.
- DUT stuck at 1, defaults. -> FINISH after edge 80 (vector 3'b111 fails); fail_vec=3'b111, exp_out=0, act_out=1, pass=0, err_count=1.
- STOP_ON_FAIL=0, DUT = AND3 vs reference NAND3. -> all 8 vectors mismatch; err_count=8; fail_vec=3'b000, exp_out=1, act_out=0; done at edge 80.
- Pulse start at edges 5 and 40 during a sweep. -> both ignored; done still at edge 80. A start in FINISH restarts: done=0, vec=0, err_count=0.
- Assert rst_n=0 at edge 35 (vec=3). -> all outputs 0 immediately without waiting for a clock edge. After release, start gives a clean full sweep with pass=1.
- HOLD_CYCLES=1, N_IN=2, correct DUT. -> vec sequence 0,1,2,3 on consecutive cycles; done at edge 4; vec holds 3.

Source files
------------

// File: rtl/vec_sweep_checker.sv
// Exhaustive-vector sweep engine: walks every N_IN-bit input combination, holds each
// for HOLD_CYCLES clocks and checks the DUT response against the reference at the end.
module vec_sweep_checker #(
  parameter int N_IN         = 3,
  parameter int OUT_W        = 1,
  parameter int HOLD_CYCLES  = 10,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   vec,
  input  logic [OUT_W-1:0]  dut_out,
  input  logic [OUT_W-1:0]  ref_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN-1:0]   fail_vec,
  output logic [OUT_W-1:0]  exp_out,
  output logic [OUT_W-1:0]  act_out,
  output logic [N_IN:0]     err_count
);

  localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] VEC_LAST  = '1;
  localparam logic [N_IN:0]   ERR_MAX   = '1;

  typedef enum logic [1:0] {IDLE, APPLY, FINISH} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [HC_W-1:0]   hold_q, hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [N_IN-1:0]   fail_vec_q, fail_vec_d;
  logic [OUT_W-1:0]  exp_q, exp_d;
  logic [OUT_W-1:0]  act_q, act_d;
  logic [N_IN:0]     err_q, err_d;
  logic              mismatch;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    hold_d     = hold_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_vec_d = fail_vec_q;
    exp_d      = exp_q;
    act_d      = act_q;
    err_d      = err_q;
    mismatch   = (dut_out != ref_out);

    case (state_q)
      IDLE, FINISH: begin
        if (start) begin
          state_d    = APPLY;
          vec_d      = '0;
          hold_d     = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          err_d      = '0;
          fail_vec_d = '0;
          exp_d      = '0;
          act_d      = '0;
        end
      end
      APPLY: begin
        if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end else begin
          // Check edge: responses are only trusted once the vector has settled.
          if (mismatch) begin
            if (err_q == '0) begin
              fail_vec_d = vec_q;
              exp_d      = ref_out;
              act_d      = dut_out;
            end
            if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          end
          if ((mismatch && (STOP_ON_FAIL != 0)) || (vec_q == VEC_LAST)) begin
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !mismatch && (err_q == '0);
          end else begin
            vec_d  = vec_q + 1'b1;
            hold_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      hold_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_vec_q <= '0;
      exp_q      <= '0;
      act_q      <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      hold_q     <= hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_vec_q <= fail_vec_d;
      exp_q      <= exp_d;
      act_q      <= act_d;
      err_q      <= err_d;
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_vec  = fail_vec_q;
  assign exp_out   = exp_q;
  assign act_out   = act_q;
  assign err_count = err_q;

endmodule
